// File: rtl/wall_layer_merge_if.sv
// Sample-in / packet-out bundle for wall_layer_merge.
// slave = the merge block, master = the upstream checkers plus the downstream renderer.
interface wall_layer_merge_if #(
    parameter int LAYERS = 5
);
    localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;

    logic                  in_valid;
    logic                  in_ready;
    logic [9:0]            in_col;
    logic [LAYERS-1:0]     in_en;
    logic [10*LAYERS-1:0]  in_x;
    logic [10*LAYERS-1:0]  in_y;
    logic [10*LAYERS-1:0]  in_z;

    logic                  wr_valid;
    logic                  wr_ready;
    logic [9:0]            wr_col;
    logic                  wr_hit;
    logic [LW-1:0]         wr_layer;
    logic [5:0]            wr_u;
    logic [5:0]            wr_v;

    modport slave (
        input  in_valid, in_col, in_en, in_x, in_y, in_z, wr_ready,
        output in_ready, wr_valid, wr_col, wr_hit, wr_layer, wr_u, wr_v
    );

    modport master (
        output in_valid, in_col, in_en, in_x, in_y, in_z, wr_ready,
        input  in_ready, wr_valid, wr_col, wr_hit, wr_layer, wr_u, wr_v
    );
endinterface

// File: rtl/wall_layer_merge.sv
// Nearest-layer select per screen column, one-stage register, show-ahead packet FIFO.
// Optional hit/miss counters are built when WALL_MERGE_STATS_EN is defined.
module wall_layer_merge #(
    parameter int LAYERS     = 5,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    wall_layer_merge_if.slave   bus
`ifdef WALL_MERGE_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count
`endif
);
    localparam int LW = (LAYERS > 1) ? $clog2(LAYERS) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [9:0]    col;
        logic          hit;
        logic [LW-1:0] layer;
        logic [5:0]    u;
        logic [5:0]    v;
    } pkt_t;

    logic            accept;
    logic            s1_valid;
    pkt_t            s1_pkt;
    pkt_t            s1_next;
    logic            push;
    logic            pop;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    pkt_t            head;
    pkt_t            mem [FIFO_DEPTH];

    logic            sel_found;
    logic signed [9:0] sel_z;
    logic [LW-1:0]   sel_idx;
    logic [5:0]      sel_u;
    logic [5:0]      sel_v;

    // Strict less-than keeps the earliest lane on equal depth.
    // NOTE: combinational blocks use blocking '=' so later loop iterations see earlier results.
    always_comb begin
        sel_found = 1'b0;
        sel_z     = '0;
        sel_idx   = '0;
        sel_u     = '0;
        sel_v     = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (bus.in_en[i] && (!sel_found || $signed(bus.in_z[10*i +: 10]) < sel_z)) begin
                sel_found = 1'b1;
                sel_z     = $signed(bus.in_z[10*i +: 10]);
                sel_idx   = LW'(i);
                sel_u     = bus.in_x[10*i +: 6];
                sel_v     = bus.in_y[10*i +: 6];
            end
        end
    end

    always_comb begin
        s1_next     = '0;
        s1_next.col = bus.in_col;
        if (sel_found) begin
            s1_next.hit   = 1'b1;
            s1_next.layer = sel_idx;
            s1_next.u     = sel_u;
            s1_next.v     = sel_v;
        end
    end

    // Ready threshold leaves room for the entry still sitting in stage 1.
    assign bus.in_ready = !rst && (count <= CW'(FIFO_DEPTH - 2));
    assign accept       = bus.in_valid && bus.in_ready;
    assign push         = s1_valid;
    assign pop          = bus.wr_valid && bus.wr_ready;

    // NOTE: sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) s1_valid <= 1'b0;
        else     s1_valid <= accept;
    end

    // NOTE: payload registers and the FIFO array carry no reset; only the valid/pointer state does.
    always_ff @(posedge clk) begin
        if (accept) s1_pkt <= s1_next;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= s1_pkt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs read as zero whenever the buffer is empty, including right after reset.
    assign head         = (count != '0) ? mem[rd_ptr] : '0;
    assign bus.wr_valid = (count != '0);
    assign bus.wr_col   = head.col;
    assign bus.wr_hit   = head.hit;
    assign bus.wr_layer = head.layer;
    assign bus.wr_u     = head.u;
    assign bus.wr_v     = head.v;

    logic unused_lane_bits;
    assign unused_lane_bits = ^{bus.in_x, bus.in_y};

`ifdef WALL_MERGE_STATS_EN
    // Clear beats a coincident increment; both counters stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (push) begin
            if (s1_pkt.hit && hit_count != 16'hFFFF)    hit_count  <= hit_count + 1'b1;
            if (!s1_pkt.hit && miss_count != 16'hFFFF)  miss_count <= miss_count + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_wall_layer_merge.sv
// Randomised bench for wall_layer_merge against a rule-level model of nearest-layer selection
// and an in-order packet queue.
module tb_wall_layer_merge;
    localparam int LAYERS = 5;
    localparam int FD     = 8;
    localparam int LW     = 3;

    typedef struct packed {
        logic [9:0]    col;
        logic          hit;
        logic [LW-1:0] layer;
        logic [5:0]    u;
        logic [5:0]    v;
    } pkt_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    pkt_t exp_q[$];
    pkt_t got_q[$];

    always #5 clk = ~clk;

    wall_layer_merge_if #(.LAYERS(LAYERS)) bus();

`ifdef WALL_MERGE_STATS_EN
    logic        stats_clr;
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    wall_layer_merge #(.LAYERS(LAYERS), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef WALL_MERGE_STATS_EN
        ,
        .stats_clr(stats_clr),
        .hit_count(hit_count),
        .miss_count(miss_count)
`endif
    );

    // Nearest = minimum signed depth over enabled lanes; first lane at that depth wins.
    function automatic pkt_t model(input logic [9:0] col, input logic [LAYERS-1:0] en,
                                   input logic [10*LAYERS-1:0] x, input logic [10*LAYERS-1:0] y,
                                   input logic [10*LAYERS-1:0] z);
        pkt_t p;
        int best;
        logic signed [9:0] zs;
        p = '0;
        p.col = col;
        best = 512;
        for (int i = 0; i < LAYERS; i++) begin
            zs = z[10*i +: 10];
            if (en[i] && int'(zs) < best) best = int'(zs);
        end
        for (int i = 0; i < LAYERS; i++) begin
            zs = z[10*i +: 10];
            if (en[i] && int'(zs) == best) begin
                p.hit   = 1'b1;
                p.layer = LW'(i);
                p.u     = x[10*i +: 6];
                p.v     = y[10*i +: 6];
                return p;
            end
        end
        return p;
    endfunction

    function automatic pkt_t cur();
        pkt_t p;
        p.col   = bus.wr_col;
        p.hit   = bus.wr_hit;
        p.layer = bus.wr_layer;
        p.u     = bus.wr_u;
        p.v     = bus.wr_v;
        return p;
    endfunction

    // Observe handshakes mid-cycle: accepted samples feed the model queue, popped packets the got queue.
    always @(negedge clk) begin
        if (!rst && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_col, bus.in_en, bus.in_x, bus.in_y, bus.in_z));
        if (!rst && bus.wr_valid && bus.wr_ready)
            got_q.push_back(cur());
        assert (!(dut.s1_valid && dut.count == FD))
            else $error("FAIL fifo_overflow push while full");
    end

    task automatic rand_lanes();
        for (int i = 0; i < LAYERS; i++) begin
            bus.in_x[10*i +: 10] = 10'($urandom);
            bus.in_y[10*i +: 10] = 10'($urandom);
            bus.in_z[10*i +: 10] = ($urandom_range(0, 3) == 0) ? 10'($urandom)
                                                               : 10'($urandom_range(0, 7)) - 10'd4;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic send(input logic [9:0] col, input logic [LAYERS-1:0] en);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_col   = col;
        bus.in_en    = en;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout col=%0d never accepted", col);
        end
    endtask

    task automatic wait_got(input int n, input int budget);
        int c;
        c = 0;
        while (got_q.size() < n && c < budget) begin
            @(posedge clk); #1;
            c++;
        end
        if (got_q.size() < n) begin
            tests++; fails++;
            $display("FAIL drain_timeout got=%0d want=%0d", got_q.size(), n);
        end
    endtask

    task automatic compare_queues(input string name);
        tests++;
        if (got_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL %s_count got=%0d want=%0d", name, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (got_q[i] !== exp_q[i]) begin
                fails++;
                $display("FAIL %s_pkt[%0d] got=%h want=%h", name, i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        tests++;
        if (bus.wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid got=%b want=0", bus.wr_valid); end
        tests++;
        if (cur() !== pkt_t'(0)) begin fails++; $display("FAIL reset_outputs got=%h want=0", cur()); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_release_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_single_hit();
        pkt_t want;
        exp_q.delete(); got_q.delete();
        bus.wr_ready = 1'b1;
        bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
        bus.in_x[20 +: 10] = 10'h0A5;
        bus.in_y[20 +: 10] = 10'h013;
        bus.in_z[20 +: 10] = 10'd128;
        bus.in_col = 10'd37; bus.in_en = 5'b00100; bus.in_valid = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL hit_ready got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        tests++;
        if (bus.wr_valid !== 1'b0) begin fails++; $display("FAIL hit_latency1 wr_valid got=%b want=0", bus.wr_valid); end
        @(posedge clk); #1;
        @(negedge clk);
        want = '{col: 10'd37, hit: 1'b1, layer: 3'd2, u: 6'h25, v: 6'h13};
        tests++;
        if (bus.wr_valid !== 1'b1) begin fails++; $display("FAIL hit_latency2 wr_valid got=%b want=1", bus.wr_valid); end
        tests++;
        if (cur() !== want) begin fails++; $display("FAIL hit_packet got=%h want=%h", cur(), want); end
        @(posedge clk); #1;
        @(negedge clk);
        tests++;
        if (bus.wr_valid !== 1'b0) begin fails++; $display("FAIL hit_popped wr_valid got=%b want=0", bus.wr_valid); end
        @(posedge clk); #1;
        compare_queues("hit");
    endtask

    task automatic test_nearest();
        logic [5:0] u3 [2];
        exp_q.delete(); got_q.delete();
        bus.wr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            rand_lanes();
            bus.in_z[10 +: 10] = 10'd192;
            bus.in_z[30 +: 10] = (k == 0) ? 10'd64 : 10'h3C0;
            bus.in_z[40 +: 10] = 10'd64;
            u3[k] = bus.in_x[30 +: 6];
            send(10'(100 + k), 5'b11010);
        end
        wait_got(2, 20);
        for (int k = 0; k < 2 && k < got_q.size(); k++) begin
            tests++;
            if (got_q[k].layer !== 3'd3 || got_q[k].u !== u3[k]) begin
                fails++;
                $display("FAIL nearest[%0d] layer=%0d u=%h want layer=3 u=%h", k, got_q[k].layer, got_q[k].u, u3[k]);
            end
        end
        compare_queues("nearest");
    endtask

    task automatic test_miss();
        pkt_t want;
        exp_q.delete(); got_q.delete();
        bus.wr_ready = 1'b1;
        rand_lanes();
        send(10'd600, '0);
        wait_got(1, 20);
        want = '{col: 10'd600, hit: 1'b0, layer: '0, u: '0, v: '0};
        tests++;
        if (got_q.size() < 1 || got_q[0] !== want) begin
            fails++;
            $display("FAIL miss_packet got=%h want=%h", (got_q.size() > 0) ? got_q[0] : pkt_t'(0), want);
        end
    endtask

    task automatic test_backpressure();
        int   next_col;
        int   unstable;
        bit   seen;
        pkt_t held;
        exp_q.delete(); got_q.delete();
        next_col = 0; unstable = 0; seen = 1'b0;
        bus.wr_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_en    = 5'b11111;
        for (int c = 0; c < 20; c++) begin
            bus.in_col = 10'(next_col);
            rand_lanes();
            @(negedge clk);
            if (bus.in_ready) next_col++;
            if (bus.wr_valid) begin
                if (!seen) begin held = cur(); seen = 1'b1; end
                else if (cur() !== held) unstable++;
            end
            @(posedge clk); #1;
        end
        @(negedge clk);
        tests++;
        if (next_col !== FD) begin fails++; $display("FAIL bp_accepted got=%0d want=%0d", next_col, FD); end
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready got=%b want=0", bus.in_ready); end
        tests++;
        if (!seen || unstable !== 0 || held.col !== 10'd0) begin
            fails++;
            $display("FAIL bp_stall_stable changes=%0d head_col=%0d want 0 changes, col 0", unstable, held.col);
        end
        @(posedge clk); #1;
        bus.wr_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            bus.in_col = 10'(next_col);
            rand_lanes();
            @(negedge clk);
            if (bus.in_ready) next_col++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        wait_got(next_col, 40);
        for (int i = 0; i < got_q.size(); i++) begin
            tests++;
            if (got_q[i].col !== 10'(i)) begin fails++; $display("FAIL bp_order[%0d] col=%0d want=%0d", i, got_q[i].col, i); end
        end
        compare_queues("bp");
    endtask

    task automatic test_random();
        int   unstable;
        bit   stalled;
        pkt_t held;
        exp_q.delete(); got_q.delete();
        unstable = 0; stalled = 1'b0;
        for (int c = 0; c < 600; c++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.wr_ready = ($urandom_range(0, 2) != 0);
            bus.in_col   = 10'($urandom);
            bus.in_en    = LAYERS'($urandom);
            rand_lanes();
            @(negedge clk);
            if (stalled && (bus.wr_valid !== 1'b1 || cur() !== held)) unstable++;
            stalled = bus.wr_valid && !bus.wr_ready;
            held    = cur();
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b1;
        wait_got(exp_q.size(), 40);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (unstable !== 0) begin fails++; $display("FAIL rand_stall_stable changes=%0d want=0", unstable); end
        compare_queues("rand");
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); got_q.delete();
        bus.wr_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_lanes();
            send(10'(200 + k), LAYERS'($urandom));
        end
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        tests++;
        if (bus.wr_valid !== 1'b1) begin fails++; $display("FAIL rstmid_prefill wr_valid got=%b want=1", bus.wr_valid); end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready_in_rst got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); got_q.delete();
        @(negedge clk);
        tests++;
        if (bus.wr_valid !== 1'b0 || cur() !== pkt_t'(0)) begin
            fails++;
            $display("FAIL rstmid_cleared wr_valid=%b pkt=%h want 0/0", bus.wr_valid, cur());
        end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_ready_after got=%b want=1", bus.in_ready); end
        @(posedge clk); #1;
        bus.wr_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        tests++;
        if (got_q.size() !== 0) begin fails++; $display("FAIL rstmid_stale got=%0d packets want=0", got_q.size()); end
        rand_lanes();
        send(10'd321, LAYERS'($urandom));
        wait_got(1, 20);
        compare_queues("rstmid");
    endtask

`ifdef WALL_MERGE_STATS_EN
    task automatic test_stats();
        exp_q.delete(); got_q.delete();
        bus.wr_ready = 1'b1;
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_lanes();
            send(10'(400 + k), (k == 1 || k == 3) ? '0 : 5'b00001 << (k % LAYERS));
        end
        wait_got(5, 20);
        tests++;
        if (hit_count !== 16'd3 || miss_count !== 16'd2) begin
            fails++;
            $display("FAIL stats_counts hit=%0d miss=%0d want 3/2", hit_count, miss_count);
        end
        rand_lanes();
        send(10'd450, 5'b00100);
        stats_clr = 1'b1;
        @(posedge clk); #1;
        stats_clr = 1'b0;
        @(negedge clk);
        tests++;
        if (hit_count !== 16'd0 || miss_count !== 16'd0) begin
            fails++;
            $display("FAIL stats_clr_wins hit=%0d miss=%0d want 0/0", hit_count, miss_count);
        end
        @(posedge clk); #1;
        wait_got(6, 20);
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.wr_ready = 1'b0;
        bus.in_col   = '0;
        bus.in_en    = '0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_z     = '0;
`ifdef WALL_MERGE_STATS_EN
        stats_clr    = 1'b0;
`endif
        test_reset();
        test_single_hit();
        test_nearest();
        test_miss();
        test_backpressure();
        test_random();
        test_reset_mid();
`ifdef WALL_MERGE_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/wall_layer_merge.md
Name: wall_layer_merge

Overview:
- Downstream of the per-layer wall validity checkers; consumes one {en, x, y, z, p} lane per wall layer in each sample cycle.
- Picks the nearest valid layer for the current screen column and forms a texture-lookup packet.
- Buffers packets in a small show-ahead FIFO and drains them to the column renderer / framebuffer writer over a valid/ready handshake.

Parameters:
- LAYERS, 5: number of layer lanes; 1..8.
- FIFO_DEPTH, 8: packet buffer entries; power of 2, >= 4.
- LW, $clog2(LAYERS) (min 1): width of the layer index (localparam).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  lane vector and in_col are a real sample this cycle
- in_ready  output  1  block accepts a sample this cycle
- in_col  input  10  screen column of the sample
- in_en  input  LAYERS  per-lane hit flag; bit i = lane i
- in_x  input  10*LAYERS  packed signed x, lane i at [10i+9:10i]
- in_y  input  10*LAYERS  packed signed y, same packing
- in_z  input  10*LAYERS  packed signed z (layer depth), same packing
- wr_valid  output  1  packet available
- wr_ready  input  1  consumer takes the packet
- wr_col  output  10  column
- wr_hit  output  1  1 = a wall was hit; 0 = background
- wr_layer  output  LW  winning lane index
- wr_u  output  6  texture u = winning x[5:0]
- wr_v  output  6  texture v = winning y[5:0]

Behaviour:
- Sample accepted when in_valid && in_ready. Lane data is ignored when not accepted.
- Stage 1 (registered, 1 cycle): among lanes with in_en=1, select the smallest z (signed compare). Ties go to the lowest lane index. in_p is not a port; column comes from in_col.
- Stage 1 register contents: col; hit = |in_en; layer; u; v; s1_valid.
  - No lane enabled: hit=0, layer=0, u=0, v=0, col=in_col. Still pushed, so every accepted column yields exactly one packet.
- FIFO push when s1_valid. Push to FIFO occurs on the edge after stage 1 loads, so an accepted sample is first visible at wr_* 2 cycles after acceptance when the FIFO is empty.
- FIFO is show-ahead: wr_* = head entry; wr_valid = (count != 0). Pop when wr_valid && wr_ready.
- wr_* hold stable while wr_valid && !wr_ready.
- in_ready = !rst && (count <= FIFO_DEPTH-2). This covers the in-flight stage-1 entry, so the FIFO never overflows. Push-while-full is unreachable and is an assertion failure in the testbench.
- Simultaneous push and pop: count unchanged, both pointers advance. Simultaneous push and pop while empty: no pop, because wr_valid was 0.
- Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits.
- Order is preserved: packets leave in acceptance order.
- Reset (synchronous, any time including mid-drain) takes effect on the next edge:
  - s1_valid=0; rd_ptr=wr_ptr=count=0.
  - wr_valid=0; wr_col=0, wr_hit=0, wr_layer=0, wr_u=0, wr_v=0 (head mux reads zeroed entry 0, or outputs forced to 0 while count=0).
  - in_ready=0 while rst is high.
  - Buffered and in-flight samples are discarded.

Optional Feature:
- Macro WALL_MERGE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Increment on each FIFO push with hit=1 / hit=0 respectively; both saturate at 16'hFFFF; both cleared by rst.
  - Adds input stats_clr (1 bit), which synchronously zeroes both counters. If stats_clr and an increment coincide, clear wins.
- Not defined: these ports and the associated logic do not exist. All other behaviour is identical.

Test Plan:
- Single hit: LAYERS=5, in_col=37, only lane 2 en, x=10'h0A5, y=10'h013, z=128, wr_ready=1 -> 2 cycles later one packet: col=37, hit=1, layer=2, u=6'h25, v=6'h13.
- Nearest select: lanes 1,3,4 en, z=192/64/64 -> layer=3 (lowest-z tie, lowest index wins). Same with lane 3 z=-64 -> layer=3.
- Miss: in_valid=1, in_en=0, in_col=600 -> packet col=600, hit=0, layer=0, u=0, v=0.
- Backpressure: wr_ready=0, in_valid=1 continuously with cols 0,1,2,...
  - in_ready drops once count=FIFO_DEPTH-1; FIFO fills to exactly 8, no loss.
  - Then wr_ready=1 -> cols drain 0..7 in order, stable while stalled.
  - Streaming resumes with the next col = last accepted+1.
- Reset mid-operation: 5 packets buffered, assert rst 1 cycle -> next cycle wr_valid=0, count=0, in_ready=0 during rst, 1 after. The old packets never appear.
- Stats (WALL_MERGE_STATS_EN): 3 hits + 2 misses -> hit_count=3, miss_count=2. stats_clr coincident with a hit -> both 0.
